// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 8-bit processor: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, issues datapath strobes and guards memory waits with a timeout.
module multicycle_control_unit #(
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_ready,
  input  logic             eq,
  output logic             mem_req,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             J,
  output logic             JC,
  output logic             INA,
  output logic             RM,
  output logic             WM,
  output logic             SIN,
  output logic             SOUT,
  output logic             WR,
  output logic             NEQ,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [OP_W-1:0] op_q;
  logic [2:0]      op3;
  logic [WC_W-1:0] wait_cnt;
  logic            waiting, expired, legal, retire;

  assign op3 = 3'(op_q);

  generate
    if (OP_W > 3) begin : g_wide
      assign legal = (op_q[OP_W-1:3] == '0);
    end else begin : g_narrow
      assign legal = 1'b1;
    end
  endgenerate

  // A ready arriving on the limit cycle completes normally instead of expiring.
  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign expired = waiting && !mem_ready && (TIMEOUT != 0) && (wait_cnt == WC_W'(TIMEOUT));
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= opcode;
      if (waiting && !mem_ready && !expired && (TIMEOUT != 0)) wait_cnt <= wait_cnt + 1'b1;
      else                                                     wait_cnt <= '0;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    mem_req   = 1'b0;
    ir_we     = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    J         = 1'b0;
    JC        = 1'b0;
    INA       = 1'b0;
    RM        = 1'b0;
    WM        = 1'b0;
    SIN       = 1'b0;
    SOUT      = 1'b0;
    WR        = 1'b0;
    NEQ       = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (expired) begin
          bus_err = 1'b1;
        end else begin
          mem_req = 1'b1;
          RM      = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = S_DECODE;
          end
        end
      end
      S_DECODE: state_nxt = run ? S_EXEC : S_IDLE;
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (!legal) begin
          illegal = 1'b1;
        end else begin
          retire = 1'b1;
          case (op3)
            3'b000: SOUT = 1'b1;
            3'b001: begin INA = 1'b1; SIN = 1'b1; end
            3'b010, 3'b011: begin retire = 1'b0; state_nxt = S_MEM; end
            3'b100: begin J = 1'b1; pc_load = 1'b1; end
            3'b101: begin JC = 1'b1; pc_load = eq; end
            3'b110: WR = 1'b1;
            default: begin JC = 1'b1; NEQ = 1'b1; pc_load = !eq; end
          endcase
        end
      end
      S_MEM: begin
        if (expired) begin
          bus_err   = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          mem_req = 1'b1;
          if (op3 == 3'b010) WM = 1'b1;
          else               RM = 1'b1;
          if (mem_ready) begin
            retire    = (op3 == 3'b010);
            state_nxt = (op3 == 3'b010) ? S_FETCH : S_WB;
          end
        end
      end
      S_WB: begin
        WR        = 1'b1;
        RM        = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
